ssram_rmw_controller: RTL and testbench
=======================================

Name: ssram_rmw_controller

Overview:
- Initiator-side controller for the synchronous-read SRAM primitive: write enable, clock enable, 1-cycle registered read.
- Accepts valid/ready word requests from a CPU-side client and sequences the SRAM port.
- Returns read data with a response pulse.
- Implements byte-lane stores by read-modify-write, because the SRAM has no byte enables.

Parameters:
- WIDTH, 32: data width in bits; must be a multiple of 8; LANES = WIDTH/8.
- ADDRESS_SIZE, 11: word address width; matches the SRAM address port.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  client request present.
- req_ready  out  1  controller accepts a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_address  in  ADDRESS_SIZE  word address.
- req_wdata  in  WIDTH  store data.
- req_byte_en  in  LANES  store lane mask; bit i covers bits [8i+7:8i].
- resp_valid  out  1  one-cycle pulse: load data valid.
- resp_rdata  out  WIDTH  load data; meaningful only while resp_valid.
- sram_address  out  ADDRESS_SIZE  to SRAM address.
- sram_data_in  out  WIDTH  to SRAM write data.
- sram_write_enable  out  1  to SRAM write enable.
- sram_clock_enable  out  1  to SRAM clock enable.
- sram_data_out  in  WIDTH  SRAM registered read data.

Behaviour:
- Reset and interface rules:
  - Single clock; reset is synchronous and active-high. While reset is high: req_ready=0, resp_valid=0, sram_write_enable=0, sram_clock_enable=0. The state goes to IDLE at the edge.
  - resp_valid, sram_write_enable and sram_clock_enable are never asserted in the reset cycle, even if req_valid=1.
  - Accept = req_valid & req_ready. Request fields are sampled only on accept. No response backpressure; the client must take resp_valid when it is asserted.
- States: IDLE, READ_WAIT, RMW_READ, RMW_WRITE. req_ready=1 only in IDLE (see the optional feature).
- IDLE, on accept, SRAM driven combinationally from the request:
  - Load: sram_address=req_address, ce=1, we=0, go to READ_WAIT.
  - Full store (byte_en all ones): address, data_in=req_wdata, ce=1, we=1. Completes this cycle; stay IDLE.
  - Partial store (mask nonzero, not all ones): ce=1, we=0. Latch address, wdata and mask; go to RMW_READ.
  - Empty store (mask zero): accepted, ce=0, no SRAM access; stay IDLE.
- READ_WAIT: resp_valid=1, resp_rdata=sram_data_out; ce=0; go to IDLE. Load latency is request accept to resp_valid = 1 cycle, so throughput is 1 load per 2 cycles.
- RMW_READ: sram_data_out holds the old word; ce=0. Register merged = per lane, mask ? wdata lane : old lane. Go to RMW_WRITE.
- RMW_WRITE: sram_address=latched address, data_in=merged, ce=1, we=1; go to IDLE. A partial store occupies 3 cycles with req_ready low for 2.
- Outputs when the port is unused: sram_data_in and sram_address are don't-care when ce=0. Drive the last values, no X.
- Ordering: requests complete strictly in order. A load after a store to the same address returns the stored data, since the write commits before the next accept.
- Reset mid-operation: any in-flight RMW or load is abandoned; no SRAM write is issued and no response is produced.
- No X propagation: unused lanes of sram_data_in come from old data.

Optional Feature:
- Macro: SSRAM_RMW_PIPELINE_EN.
- Defined: req_ready=1 in READ_WAIT as well as IDLE.
  - An accept in READ_WAIT is handled exactly as an accept in IDLE.
  - The resp_valid for the previous load is emitted in the same cycle.
  - A load accepted in READ_WAIT stays in READ_WAIT, so back-to-back loads run at 1 per cycle with 1-cycle latency.
  - A full store in READ_WAIT goes to IDLE; a partial store goes to RMW_READ.
- Undefined: req_ready=0 in READ_WAIT, as specified above.

Test Plan:
- Reset: hold reset high for 3 cycles with req_valid=1 -> req_ready=0, ce=0, we=0, resp_valid=0 every cycle; after release, req_ready=1 in IDLE.
- Full store then load: store 0xDEADBEEF to addr 5 with mask 4'b1111, then load addr 5 -> one SRAM write cycle; resp_valid exactly 1 cycle after the load accept with rdata=0xDEADBEEF.
- Partial store: word 0x11223344 at addr 9, store 0xAABBCCDD with mask 4'b0101 -> req_ready low for 2 cycles; a subsequent load returns 0x11BB33DD.
- Empty mask: store 0xFFFFFFFF with mask 4'b0000 to addr 2, which holds 0x12345678 -> no ce pulse; a later load returns 0x12345678.
- Reset mid-RMW: partial store to addr 3, which holds 0x0, with reset asserted in the RMW_WRITE cycle -> we=0 that cycle; addr 3 still reads 0x0.
- Pipeline (macro defined): loads to addrs 0,1,2,3 on consecutive cycles -> req_ready stays 1; resp_valid high 4 consecutive cycles with data in order.

Source files
------------

// File: rtl/ssram_rmw_controller.sv
// Request/response controller for a synchronous-read SRAM with byte-lane stores by read-modify-write.
// Optional SSRAM_RMW_PIPELINE_EN: also accept requests in READ_WAIT for 1-per-cycle loads.
module ssram_rmw_controller #(
  parameter  int WIDTH        = 32,
  parameter  int ADDRESS_SIZE = 11,
  localparam int LANES        = WIDTH / 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDRESS_SIZE-1:0] req_address,
  input  logic [WIDTH-1:0]        req_wdata,
  input  logic [LANES-1:0]        req_byte_en,
  output logic                    resp_valid,
  output logic [WIDTH-1:0]        resp_rdata,
  output logic [ADDRESS_SIZE-1:0] sram_address,
  output logic [WIDTH-1:0]        sram_data_in,
  output logic                    sram_write_enable,
  output logic                    sram_clock_enable,
  input  logic [WIDTH-1:0]        sram_data_out
);

  typedef enum logic [1:0] {IDLE, READ_WAIT, RMW_READ, RMW_WRITE} state_t;

  state_t                  state_q, state_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]        wdata_q, wdata_d;
  logic [LANES-1:0]        mask_q, mask_d;
  logic [WIDTH-1:0]        merged_q, merged_d;
  logic [ADDRESS_SIZE-1:0] sram_addr_q, sram_addr_d;
  logic [WIDTH-1:0]        sram_din_q, sram_din_d;
  logic                    can_accept, ready, rvalid, ce, we;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    merged_d    = merged_q;
    sram_addr_d = sram_addr_q;
    sram_din_d  = sram_din_q;
    rvalid      = 1'b0;
    ce          = 1'b0;
    we          = 1'b0;
`ifdef SSRAM_RMW_PIPELINE_EN
    can_accept  = (state_q == IDLE) || (state_q == READ_WAIT);
`else
    can_accept  = (state_q == IDLE);
`endif
    ready       = can_accept;

    case (state_q)
      READ_WAIT: begin
        rvalid  = 1'b1;
        state_d = IDLE;
      end
      RMW_READ: begin
        for (int l = 0; l < LANES; l++)
          merged_d[8*l +: 8] = mask_q[l] ? wdata_q[8*l +: 8] : sram_data_out[8*l +: 8];
        state_d = RMW_WRITE;
      end
      RMW_WRITE: begin
        sram_addr_d = addr_q;
        sram_din_d  = merged_q;
        ce          = 1'b1;
        we          = 1'b1;
        state_d     = IDLE;
      end
      default: ;
    endcase

    // An accept in READ_WAIT (pipelined build) overrides the return to IDLE above.
    if (can_accept && req_valid) begin
      if (!req_write) begin
        sram_addr_d = req_address;
        ce          = 1'b1;
        state_d     = READ_WAIT;
      end else if (&req_byte_en) begin
        sram_addr_d = req_address;
        sram_din_d  = req_wdata;
        ce          = 1'b1;
        we          = 1'b1;
        state_d     = IDLE;
      end else if (|req_byte_en) begin
        sram_addr_d = req_address;
        ce          = 1'b1;
        addr_d      = req_address;
        wdata_d     = req_wdata;
        mask_d      = req_byte_en;
        state_d     = RMW_READ;
      end else begin
        state_d     = IDLE;
      end
    end

    if (reset) begin
      ready  = 1'b0;
      rvalid = 1'b0;
      ce     = 1'b0;
      we     = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      merged_q    <= '0;
      sram_addr_q <= '0;
      sram_din_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      merged_q    <= merged_d;
      sram_addr_q <= sram_addr_d;
      sram_din_q  <= sram_din_d;
    end
  end

  assign req_ready         = ready;
  assign resp_valid        = rvalid;
  assign resp_rdata        = sram_data_out;
  assign sram_address      = sram_addr_d;
  assign sram_data_in      = sram_din_d;
  assign sram_write_enable = we;
  assign sram_clock_enable = ce;

endmodule

// File: tb/tb_ssram_rmw_controller.sv
// Randomized self-checking bench: SRAM primitive model plus a word-array reference of memory contents.
module tb_ssram_rmw_controller;

`ifdef SSRAM_RMW_PIPELINE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [10:0] req_address;
  logic [31:0] req_wdata;
  logic [3:0]  req_byte_en;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [10:0] sram_address;
  logic [31:0] sram_data_in, sram_data_out;
  logic        sram_write_enable, sram_clock_enable;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [31:0] mem     [0:2047];
  logic [31:0] ref_mem [0:2047];

  ssram_rmw_controller #(.WIDTH(32), .ADDRESS_SIZE(11)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata), .req_byte_en(req_byte_en),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .sram_address(sram_address), .sram_data_in(sram_data_in),
    .sram_write_enable(sram_write_enable), .sram_clock_enable(sram_clock_enable),
    .sram_data_out(sram_data_out)
  );

  always #5 clock = ~clock;

  // SRAM primitive: 1-cycle registered read, output holds when not reading.
  always @(posedge clock) begin
    if (sram_clock_enable) begin
      if (sram_write_enable) mem[sram_address] <= sram_data_in;
      else                   sram_data_out     <= mem[sram_address];
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One request: drive, wait for accept, check SRAM strobes and the follow-up cycles.
  task automatic op(input logic w, input logic [10:0] a, input logic [31:0] d, input logic [3:0] be);
    int n;
    logic [31:0] exp;
    logic exp_ce, exp_we;
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = w; req_address = a; req_wdata = d; req_byte_en = be;
    n = 0;
    @(negedge clock);
    while (!req_ready && n < 20) begin @(negedge clock); n++; end
    if (!req_ready) begin
      $display("FAIL accept_timeout: req_ready=%b required 1 addr=%0d", req_ready, a);
      chk_cnt++;
      req_valid = 1'b0;
      return;
    end
    exp_ce = w ? (be != 4'h0) : 1'b1;
    exp_we = w && (be == 4'hF);
    if (sram_clock_enable !== exp_ce || sram_write_enable !== exp_we ||
        (exp_ce && sram_address !== a) || (exp_we && sram_data_in !== d)) begin
      $display("FAIL accept_strobe: ce=%b we=%b addr=%0d din=%h required ce=%b we=%b addr=%0d din=%h",
               sram_clock_enable, sram_write_enable, sram_address, sram_data_in, exp_ce, exp_we, a, d);
    end else pass_cnt++;
    chk_cnt++;
    @(posedge clock); #1;
    req_valid = 1'b0;
    if (w) begin
      for (int l = 0; l < 4; l++)
        if (be[l]) ref_mem[a][8*l +: 8] = d[8*l +: 8];
    end
    exp = ref_mem[a];
    @(negedge clock);
    if (!w) begin
      if (resp_valid !== 1'b1 || resp_rdata !== exp || req_ready !== PIPE) begin
        $display("FAIL load_resp: valid=%b rdata=%h ready=%b required 1 %h %b",
                 resp_valid, resp_rdata, req_ready, exp, PIPE);
      end else pass_cnt++;
      chk_cnt++;
    end else if (be != 4'h0 && be != 4'hF) begin
      if (resp_valid !== 1'b0 || req_ready !== 1'b0 || sram_clock_enable !== 1'b0) begin
        $display("FAIL rmw_read: valid=%b ready=%b ce=%b required 0 0 0",
                 resp_valid, req_ready, sram_clock_enable);
      end else pass_cnt++;
      chk_cnt++;
      @(negedge clock);
      if (sram_clock_enable !== 1'b1 || sram_write_enable !== 1'b1 || req_ready !== 1'b0 ||
          sram_address !== a || sram_data_in !== exp) begin
        $display("FAIL rmw_write: ce=%b we=%b ready=%b addr=%0d din=%h required 1 1 0 %0d %h",
                 sram_clock_enable, sram_write_enable, req_ready, sram_address, sram_data_in, a, exp);
      end else pass_cnt++;
      chk_cnt++;
    end else begin
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        $display("FAIL store_done: valid=%b ready=%b required 0 1", resp_valid, req_ready);
      end else pass_cnt++;
      chk_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b1;
    req_address = 11'd7; req_wdata = 32'hCAFEF00D; req_byte_en = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (req_ready !== 1'b0 || sram_clock_enable !== 1'b0 ||
          sram_write_enable !== 1'b0 || resp_valid !== 1'b0) begin
        $display("FAIL reset_hold: ready=%b ce=%b we=%b resp=%b required 0 0 0 0",
                 req_ready, sram_clock_enable, sram_write_enable, resp_valid);
      end else pass_cnt++;
      chk_cnt++;
    end
    @(posedge clock); #1;
    reset = 1'b0; req_valid = 1'b0;
    @(negedge clock);
    if (req_ready !== 1'b1 || mem[7] !== 32'h0) begin
      $display("FAIL reset_release: ready=%b mem7=%h required 1 0", req_ready, mem[7]);
    end else pass_cnt++;
    chk_cnt++;
  endtask

  task automatic test_full_store_load();
    op(1'b1, 11'd5, 32'hDEADBEEF, 4'hF);
    op(1'b0, 11'd5, 32'h0, 4'h0);
  endtask

  task automatic test_partial_store();
    op(1'b1, 11'd9, 32'h11223344, 4'hF);
    op(1'b1, 11'd9, 32'hAABBCCDD, 4'b0101);
    op(1'b0, 11'd9, 32'h0, 4'h0);
    if (ref_mem[9] !== 32'h11BB33DD || mem[9] !== 32'h11BB33DD) begin
      $display("FAIL partial_merge: mem=%h required 11bb33dd", mem[9]);
    end else pass_cnt++;
    chk_cnt++;
  endtask

  task automatic test_empty_mask();
    op(1'b1, 11'd2, 32'h12345678, 4'hF);
    op(1'b1, 11'd2, 32'hFFFFFFFF, 4'h0);
    op(1'b0, 11'd2, 32'h0, 4'h0);
  endtask

  task automatic test_reset_mid_rmw();
    op(1'b1, 11'd3, 32'h0, 4'hF);
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = 1'b1; req_address = 11'd3;
    req_wdata = 32'hFFFFFFFF; req_byte_en = 4'b0011;
    @(negedge clock);
    if (req_ready !== 1'b1) begin
      $display("FAIL midrmw_accept: ready=%b required 1", req_ready);
    end else pass_cnt++;
    chk_cnt++;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    if (sram_write_enable !== 1'b0 || sram_clock_enable !== 1'b0 || resp_valid !== 1'b0) begin
      $display("FAIL midrmw_reset: we=%b ce=%b resp=%b required 0 0 0",
               sram_write_enable, sram_clock_enable, resp_valid);
    end else pass_cnt++;
    chk_cnt++;
    @(posedge clock); #1;
    reset = 1'b0;
    op(1'b0, 11'd3, 32'h0, 4'h0);
  endtask

  task automatic test_random();
    logic [3:0] be;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0:       be = 4'hF;
        1:       be = 4'h0;
        default: be = 4'($urandom);
      endcase
      op(($urandom_range(0, 2) != 0), 11'($urandom_range(0, 15)), $urandom, be);
    end
    for (int a = 0; a < 16; a++) op(1'b0, 11'(a), 32'h0, 4'h0);
  endtask

`ifdef SSRAM_RMW_PIPELINE_EN
  task automatic test_pipeline();
    for (int a = 0; a < 4; a++) op(1'b1, 11'(a), $urandom, 4'hF);
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = 1'b0; req_byte_en = 4'h0; req_address = 11'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (i < 4) begin
        if (req_ready !== 1'b1) begin
          $display("FAIL pipe_ready[%0d]: ready=%b required 1", i, req_ready);
        end else pass_cnt++;
        chk_cnt++;
      end
      if (i > 0) begin
        if (resp_valid !== 1'b1 || resp_rdata !== ref_mem[i-1]) begin
          $display("FAIL pipe_resp[%0d]: valid=%b rdata=%h required 1 %h",
                   i - 1, resp_valid, resp_rdata, ref_mem[i-1]);
        end else pass_cnt++;
        chk_cnt++;
      end
      @(posedge clock); #1;
      if (i < 3) req_address = 11'(i + 1);
      else       req_valid = 1'b0;
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 2048; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    sram_data_out = 32'h0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_address = '0; req_wdata = '0; req_byte_en = '0;
    test_reset();
    test_full_store_load();
    test_partial_store();
    test_empty_mask();
    test_reset_mid_rmw();
    test_random();
`ifdef SSRAM_RMW_PIPELINE_EN
    test_pipeline();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
